// File: rtl/thermocouple_pkg.sv
// thermocouple_pkg
// Shared definitions for the multi-channel thermocouple scanner:
//   - scan_state_t : sequencer states
//   - frame field positions and widths of a MAX31855-style 32-bit SPI frame
package thermocouple_pkg;

    // Sequencer states of the round-robin scanner
    typedef enum logic [2:0] {
        STARTUP,
        SELECT,
        REQ,
        WAIT,
        CAPTURE,
        SETTLE
    } scan_state_t;

    // Bit positions inside the 32-bit frame
    localparam int TC_MSB  = 31;
    localparam int TC_LSB  = 18;
    localparam int FLT_BIT = 16;
    localparam int JT_MSB  = 15;
    localparam int JT_LSB  = 4;

    // Field widths of the decoded per-channel registers
    localparam int TC_W  = 14;
    localparam int JT_W  = 12;
    localparam int FLT_W = 4;

endpackage

// File: rtl/tc_channel_reg.sv
// tc_channel_reg
// Holds the decoded readings and the health state of one thermocouple channel.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   capture_en         : this channel is being captured this cycle
//   good               : the captured read is good (no fault bit, no timeout)
//   timeout            : the captured read ended in an SPI busy timeout
//   tc_field           : frame thermocouple field
//   jt_field           : frame junction field
//   flt_field          : {frame fault bit, frame[2:0]}
//   tc_temp, junction_temp, fault : registered channel values
//   valid              : at least one good reading since the last failure
//   failed             : FAULT_LIMIT consecutive bad reads
module tc_channel_reg
    import thermocouple_pkg::*;
#(
    parameter int FAULT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_en,
    input  logic             good,
    input  logic             timeout,
    input  logic [TC_W-1:0]  tc_field,
    input  logic [JT_W-1:0]  jt_field,
    input  logic [FLT_W-1:0] flt_field,
    output logic [TC_W-1:0]  tc_temp,
    output logic [JT_W-1:0]  junction_temp,
    output logic [FLT_W-1:0] fault,
    output logic             valid,
    output logic             failed
);

    localparam int FC_BITS = (FAULT_LIMIT > 1) ? $clog2(FAULT_LIMIT + 1) : 1;
    localparam logic [FC_BITS-1:0] LIMIT = FC_BITS'(FAULT_LIMIT);

    logic [FC_BITS-1:0] fault_cnt;

    // A good read refreshes every field and clears the health history.
    // A bad read only rewrites the fault field, so the last good temperatures
    // stay visible; the consecutive-fault counter saturates at the limit and
    // the channel is marked failed on the read that reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_temp       <= '0;
            junction_temp <= '0;
            fault         <= '0;
            valid         <= 1'b0;
            failed        <= 1'b0;
            fault_cnt     <= '0;
        end else if (capture_en) begin
            if (good) begin
                tc_temp       <= tc_field;
                junction_temp <= jt_field;
                fault         <= flt_field;
                valid         <= 1'b1;
                failed        <= 1'b0;
                fault_cnt     <= '0;
            end else begin
                fault <= timeout ? {1'b1, 3'b000} : flt_field;
                if (fault_cnt != LIMIT) begin
                    fault_cnt <= fault_cnt + 1'b1;
                    if (fault_cnt == LIMIT - 1'b1) begin
                        failed <= 1'b1;
                        valid  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/thermocouple_scanner.sv
// thermocouple_scanner
// Polls NUM_CH MAX31855-style devices round-robin through one shared SPI
// master and keeps decoded readings plus health flags per channel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ch_enable           : per-channel scan enable, looked at when choosing a channel
//   spi_not_busy        : SPI master idle flag
//   spi_rx_data         : last received 32-bit frame
//   spi_ena             : transfer request to the SPI master
//   spi_cs_sel          : channel currently addressed
//   tc_temp_data        : per-channel thermocouple field, channel k at [14k+13:14k]
//   junction_temp_data  : per-channel junction field, 12 bits each
//   fault_bits          : per-channel fault nibble, 4 bits each
//   ch_valid, ch_failed : per-channel health flags
//   sample_strobe       : one-cycle pulse when a capture lands in the registers
//   sample_ch           : channel of the current sample_strobe
module thermocouple_scanner
    import thermocouple_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CH_BITS        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int STARTUP_CYCLES = 300,
    parameter int SETTLE_CYCLES  = 100,
    parameter int BUSY_TIMEOUT   = 255,
    parameter int FAULT_LIMIT    = 3,
    parameter int CNT_BITS       = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     spi_not_busy,
    input  logic [31:0]              spi_rx_data,
    output logic                     spi_ena,
    output logic [CH_BITS-1:0]       spi_cs_sel,
    output logic [NUM_CH*TC_W-1:0]   tc_temp_data,
    output logic [NUM_CH*JT_W-1:0]   junction_temp_data,
    output logic [NUM_CH*FLT_W-1:0]  fault_bits,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_failed,
    output logic                     sample_strobe,
    output logic [CH_BITS-1:0]       sample_ch
);

    localparam logic [CNT_BITS-1:0] STARTUP_LAST = CNT_BITS'(STARTUP_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] SETTLE_LAST  = CNT_BITS'(SETTLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(BUSY_TIMEOUT);
    localparam logic [CH_BITS-1:0]  CH_LAST      = CH_BITS'(NUM_CH - 1);

    scan_state_t         state;
    logic [CNT_BITS-1:0] cnt;
    logic [CH_BITS-1:0]  ptr;
    logic                timeout_flag;
    logic [CH_BITS-1:0]  next_ch;
    logic                next_found;
    logic                read_good;
    logic                unused_frame_bits;

    // Frame bits 17 and 3 carry no information for this block
    assign unused_frame_bits = ^{spi_rx_data[17], spi_rx_data[3]};

    // Find the first enabled channel at or after the pointer, wrapping.
    // Walking the offsets from the far end down means the last hit, the one
    // that sticks, is the closest enabled channel.
    always_comb begin
        int idx;
        next_found = 1'b0;
        next_ch    = ptr;
        idx        = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (ch_enable[idx]) begin
                next_found = 1'b1;
                next_ch    = CH_BITS'(idx);
            end
        end
    end

    // Scan sequencer. One shared counter serves the startup wait, the busy
    // timeout and the settle gap since only one of them is ever running.
    // spi_ena rises on leaving SELECT and holds until the master goes busy.
    // sample_strobe is raised on the same edge the channel registers update,
    // so a consumer sees fresh data while the strobe is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= STARTUP;
            cnt           <= '0;
            ptr           <= '0;
            timeout_flag  <= 1'b0;
            spi_ena       <= 1'b0;
            spi_cs_sel    <= '0;
            sample_strobe <= 1'b0;
            sample_ch     <= '0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                STARTUP: begin
                    if (cnt == STARTUP_LAST) begin
                        cnt   <= '0;
                        state <= SELECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SELECT: begin
                    if (next_found) begin
                        spi_cs_sel <= next_ch;
                        spi_ena    <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (!spi_not_busy) begin
                        spi_ena <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (spi_not_busy) begin
                        timeout_flag <= 1'b0;
                        state        <= CAPTURE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_flag <= 1'b1;
                        state        <= CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    sample_strobe <= 1'b1;
                    sample_ch     <= spi_cs_sel;
                    cnt           <= '0;
                    state         <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        ptr   <= (spi_cs_sel == CH_LAST) ? '0 : spi_cs_sel + 1'b1;
                        state <= SELECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

    assign read_good = !timeout_flag && !spi_rx_data[FLT_BIT];

    // One register bank per channel; only the addressed bank sees capture_en
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            tc_channel_reg #(
                .FAULT_LIMIT (FAULT_LIMIT)
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .capture_en    ((state == CAPTURE) && (spi_cs_sel == CH_BITS'(k))),
                .good          (read_good),
                .timeout       (timeout_flag),
                .tc_field      (spi_rx_data[TC_MSB:TC_LSB]),
                .jt_field      (spi_rx_data[JT_MSB:JT_LSB]),
                .flt_field     ({spi_rx_data[FLT_BIT], spi_rx_data[2:0]}),
                .tc_temp       (tc_temp_data[TC_W*k +: TC_W]),
                .junction_temp (junction_temp_data[JT_W*k +: JT_W]),
                .fault         (fault_bits[FLT_W*k +: FLT_W]),
                .valid         (ch_valid[k]),
                .failed        (ch_failed[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_thermocouple_scanner.sv
// tb_thermocouple_scanner
// Directed, table-driven bench for thermocouple_scanner with NUM_CH=4.
// Each table row is one SPI transaction with hand-computed expectations.
module tb_thermocouple_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_enable;
    logic        spi_not_busy;
    logic [31:0] spi_rx_data;
    logic        spi_ena;
    logic [1:0]  spi_cs_sel;
    logic [55:0] tc_temp_data;
    logic [47:0] junction_temp_data;
    logic [15:0] fault_bits;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_failed;
    logic        sample_strobe;
    logic [1:0]  sample_ch;

    int total;
    int bad;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] frame;
        int          busy_len;
        bit          to;
        int          exp_ch;
        logic [13:0] tc;
        logic [11:0] jt;
        logic [3:0]  flt;
        logic [3:0]  valid;
        logic [3:0]  failed;
    } vec_t;

    vec_t        vecs[15];
    logic [13:0] sh_tc[4];
    logic [11:0] sh_jt[4];
    logic [3:0]  sh_flt[4];

    thermocouple_scanner #(
        .NUM_CH (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ch_enable          (ch_enable),
        .spi_not_busy       (spi_not_busy),
        .spi_rx_data        (spi_rx_data),
        .spi_ena            (spi_ena),
        .spi_cs_sel         (spi_cs_sel),
        .tc_temp_data       (tc_temp_data),
        .junction_temp_data (junction_temp_data),
        .fault_bits         (fault_bits),
        .ch_valid           (ch_valid),
        .ch_failed          (ch_failed),
        .sample_strobe      (sample_strobe),
        .sample_ch          (sample_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // spi_ena must stay low for exactly 300 sampled clocks after rst_n rises
    task automatic checkStartup(input string name);
        int n;
        n = 0;
        while (!spi_ena && n < 400) begin
            @(negedge clk);
            if (!spi_ena) n++;
        end
        checkOutput({name, " idle clocks"}, n, 300);
        checkOutput({name, " cs_sel"}, spi_cs_sel, 0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int w;
        int cyc;
        logic seen;
        ch_enable = v.en;
        w = 0;
        while (!spi_ena && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput($sformatf("r%0d spi_ena", idx), spi_ena, 1);
        checkOutput($sformatf("r%0d cs_sel", idx), spi_cs_sel, v.exp_ch);
        spi_rx_data  = v.frame;
        spi_not_busy = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!v.to && cyc == v.busy_len) spi_not_busy = 1'b1;
            seen = sample_strobe;
        end
        spi_not_busy = 1'b1;
        checkOutput($sformatf("r%0d latency", idx), cyc, v.to ? 258 : v.busy_len + 2);
        checkOutput($sformatf("r%0d sample_ch", idx), sample_ch, v.exp_ch);
        sh_tc[v.exp_ch]  = v.tc;
        sh_jt[v.exp_ch]  = v.jt;
        sh_flt[v.exp_ch] = v.flt;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("r%0d tc ch%0d", idx, c), tc_temp_data[14*c +: 14], sh_tc[c]);
            checkOutput($sformatf("r%0d jt ch%0d", idx, c), junction_temp_data[12*c +: 12], sh_jt[c]);
            checkOutput($sformatf("r%0d flt ch%0d", idx, c), fault_bits[4*c +: 4], sh_flt[c]);
        end
        checkOutput($sformatf("r%0d ch_valid", idx), ch_valid, v.valid);
        checkOutput($sformatf("r%0d ch_failed", idx), ch_failed, v.failed);
        @(negedge clk);
        checkOutput($sformatf("r%0d strobe width", idx), sample_strobe, 0);
    endtask

    initial begin
        int highs;
        int w;
        total = 0;
        bad   = 0;
        rst_n        = 1'b0;
        ch_enable    = 4'b1111;
        spi_not_busy = 1'b1;
        spi_rx_data  = 32'h0;
        for (int c = 0; c < 4; c++) begin
            sh_tc[c]  = '0;
            sh_jt[c]  = '0;
            sh_flt[c] = '0;
        end

        //            en       frame         busy to ch  tc       jt       flt      valid    failed
        vecs[0]  = '{4'b1111, 32'h1900_1A00, 5, 0, 0, 14'h0640, 12'h1A0, 4'b0000, 4'b0001, 4'b0000};
        vecs[1]  = '{4'b1010, 32'h0C80_0F50, 3, 0, 1, 14'h0320, 12'h0F5, 4'b0000, 4'b0011, 4'b0000};
        vecs[2]  = '{4'b1010, 32'h0400_7FF0, 1, 0, 3, 14'h0100, 12'h7FF, 4'b0000, 4'b1011, 4'b0000};
        vecs[3]  = '{4'b1010, 32'hFFFF_0001, 4, 0, 1, 14'h0320, 12'h0F5, 4'b1001, 4'b1011, 4'b0000};
        vecs[4]  = '{4'b1010, 32'h0800_1230, 2, 0, 3, 14'h0200, 12'h123, 4'b0000, 4'b1011, 4'b0000};
        vecs[5]  = '{4'b1010, 32'hFFFF_0001, 6, 0, 1, 14'h0320, 12'h0F5, 4'b1001, 4'b1011, 4'b0000};
        vecs[6]  = '{4'b1010, 32'h0400_7FF0, 2, 0, 3, 14'h0100, 12'h7FF, 4'b0000, 4'b1011, 4'b0000};
        vecs[7]  = '{4'b1010, 32'hFFFF_0001, 3, 0, 1, 14'h0320, 12'h0F5, 4'b1001, 4'b1001, 4'b0010};
        vecs[8]  = '{4'b1010, 32'h0C80_0F50, 0, 1, 3, 14'h0100, 12'h7FF, 4'b1000, 4'b1001, 4'b0010};
        vecs[9]  = '{4'b1010, 32'h0C80_0F55, 2, 0, 1, 14'h0320, 12'h0F5, 4'b0101, 4'b1011, 4'b0000};
        vecs[10] = '{4'b1010, 32'h0C80_0F50, 0, 1, 3, 14'h0100, 12'h7FF, 4'b1000, 4'b1011, 4'b0000};
        vecs[11] = '{4'b1010, 32'h0C80_0F50, 2, 0, 1, 14'h0320, 12'h0F5, 4'b0000, 4'b1011, 4'b0000};
        vecs[12] = '{4'b1010, 32'h0C80_0F50, 0, 1, 3, 14'h0100, 12'h7FF, 4'b1000, 4'b0011, 4'b1000};
        vecs[13] = '{4'b0001, 32'h3FFE_FFF8, 3, 0, 0, 14'h0FFF, 12'hFFF, 4'b0000, 4'b0011, 4'b1000};
        vecs[14] = '{4'b1000, 32'h0800_1230, 2, 0, 3, 14'h0200, 12'h123, 4'b0000, 4'b1011, 4'b0000};

        $display("[TB] reset and startup");
        repeat (3) @(negedge clk);
        checkOutput("reset spi_ena", spi_ena, 0);
        checkOutput("reset ch_valid", ch_valid, 0);
        checkOutput("reset tc", tc_temp_data[31:0], 0);
        rst_n = 1'b1;
        checkStartup("startup");

        $display("[TB] transaction table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] no channel enabled");
        ch_enable = 4'b0000;
        highs = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (spi_ena) highs++;
        end
        checkOutput("none enabled spi_ena", highs, 0);
        ch_enable = 4'b0100;
        w = 0;
        while (!spi_ena && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("reenable spi_ena", spi_ena, 1);
        checkOutput("reenable cs_sel", spi_cs_sel, 2);

        $display("[TB] async reset mid-wait");
        spi_rx_data  = 32'h1900_1A00;
        spi_not_busy = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("areset spi_ena", spi_ena, 0);
        checkOutput("areset cs_sel", spi_cs_sel, 0);
        checkOutput("areset tc lo", tc_temp_data[31:0], 0);
        checkOutput("areset tc hi", tc_temp_data[55:32], 0);
        checkOutput("areset jt lo", junction_temp_data[31:0], 0);
        checkOutput("areset jt hi", junction_temp_data[47:32], 0);
        checkOutput("areset fault", fault_bits, 0);
        checkOutput("areset valid", ch_valid, 0);
        checkOutput("areset failed", ch_failed, 0);
        checkOutput("areset strobe", {sample_strobe, sample_ch}, 0);
        spi_not_busy = 1'b1;
        ch_enable    = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        checkStartup("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thermocouple_scanner.md
Name: thermocouple_scanner

Overview:
Multi-channel successor to the single-channel thermocouple reader. After a power-up wait, it polls up to NUM_CH MAX31855-style 32-bit SPI frames round-robin through one shared SPI master, selecting the device with spi_cs_sel. Each frame is decoded into per-channel thermocouple temperature, junction temperature and fault registers. Each channel tracks consecutive faults and SPI timeouts, and a channel is declared failed after FAULT_LIMIT bad reads in a row.

Parameters:
NUM_CH, 4, number of thermocouple channels (1..16)
CH_BITS, $clog2(NUM_CH) min 1, channel index width
STARTUP_CYCLES, 300, clocks waited after reset before the first request
SETTLE_CYCLES, 100, clocks idled after each capture before the next request
BUSY_TIMEOUT, 255, max clocks in WAIT before the read counts as a fault
FAULT_LIMIT, 3, consecutive bad reads that set ch_failed
CNT_BITS, 9, counter width; must hold max(STARTUP_CYCLES, SETTLE_CYCLES, BUSY_TIMEOUT)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ch_enable  in  NUM_CH  per-channel scan enable, sampled at channel selection
spi_not_busy  in  1  SPI master idle flag
spi_rx_data  in  32  last received SPI frame
spi_ena  out  1  transfer request to the SPI master
spi_cs_sel  out  CH_BITS  channel currently addressed
tc_temp_data  out  NUM_CH*14  per-channel frame[31:18], channel k at [14k+13:14k]
junction_temp_data  out  NUM_CH*12  per-channel frame[15:4]
fault_bits  out  NUM_CH*4  per-channel {frame[16], frame[2:0]}; bit 3 also set on timeout
ch_valid  out  NUM_CH  channel holds at least one good reading since last failure
ch_failed  out  NUM_CH  FAULT_LIMIT consecutive bad reads
sample_strobe  out  1  one-cycle pulse on every capture, good or bad
sample_ch  out  CH_BITS  channel of the current sample_strobe

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state STARTUP, counters 0, channel pointer 0, fault counters 0. Reset mid-transfer abandons the frame; no register is updated.
- STARTUP: counter increments each clock. When it reaches STARTUP_CYCLES, clear the counter and go to SELECT.
- SELECT (1 clk): search from the pointer for the next channel with ch_enable=1, wrapping modulo NUM_CH. Load spi_cs_sel with it and go to REQ. If no channel is enabled, stay in SELECT with spi_ena=0.
- REQ: spi_ena=1 while spi_not_busy=1. On the first clock with spi_not_busy=0, set spi_ena=0, clear the counter and go to WAIT.
- WAIT: when spi_not_busy=1, go to CAPTURE. If the counter reaches BUSY_TIMEOUT first, go to CAPTURE flagged as timeout.
- CAPTURE (1 clk): sample_strobe=1 and sample_ch=spi_cs_sel.
  - Bad read = frame[16]=1 or timeout.
  - Good read: update the tc, junction and fault fields of the channel; clear its fault counter and ch_failed; set ch_valid.
  - Bad read: update only the fault field (timeout forces bit 3=1, other bits 0). Increment the fault counter, saturating at FAULT_LIMIT. When it reaches FAULT_LIMIT, set ch_failed and clear ch_valid. Temperature fields keep their last good values.
  - Then go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then advance the pointer to spi_cs_sel+1 (wrapping NUM_CH-1 to 0) and go to SELECT.
- A channel disabled mid-transfer finishes its current read; it is skipped from the next SELECT onward.
- Only the addressed channel's fields change in CAPTURE. Other channels hold their values.
- Latency from spi_not_busy rising in WAIT to registers updated: 2 clocks.

Decomposition:
- Shared package thermocouple_pkg holds:
  - state enum {STARTUP, SELECT, REQ, WAIT, CAPTURE, SETTLE};
  - frame field constants TC_MSB=31, TC_LSB=18, FLT_BIT=16, JT_MSB=15, JT_LSB=4, widths 14/12/4.
- One sub-module, tc_channel_reg, per channel via generate. It holds the data, fault counter, valid and failed flags, and is updated when capture_en, good and timeout are asserted.

Test Plan:
- Startup: NUM_CH=4, all enabled, hold spi_not_busy=1 -> spi_ena stays 0 for exactly 300 clocks after rst_n rises, then 1 with spi_cs_sel=0.
- Good frame: spi_rx_data=32'h1900_1A00 on ch0 -> tc ch0=14'h0640, junction ch0=12'h1A0, fault ch0=0, ch_valid[0]=1, one sample_strobe with sample_ch=0.
- Round-robin and skip: ch_enable=4'b1010 -> spi_cs_sel sequence 1,3,1,3; ch0 and ch2 fields stay 0.
- Fault limit: three consecutive frames with bit16=1, bits[2:0]=3'b001 on ch1 -> fault ch1=4'b1001; ch_failed[1]=1 after the third; ch1 temperatures unchanged. The next good frame clears ch_failed[1].
- Timeout: spi_not_busy held 0 in WAIT for 256 clocks -> CAPTURE with fault ch=4'b1000 and the fault counter incremented.
- Async reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately without a clock edge; the sequence restarts with STARTUP.
